icache_dm: RTL and testbench

Direct-mapped, read-only instruction cache between the fetch stage and main memory. Serves the fetch address combinationally on a hit and raises a stall toward fetch on a miss. On a miss it fetches the whole line over a simple request/ack, beat-per-cycle memory port, fills the line, then resumes. It also supports a whole-cache flush and exposes hit/miss counters for debug.

---
 rtl/icache_dm.sv | 156 +++++++++++++++
 tb/tb_icache_dm.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache. Hits are served combinationally;
// a miss stalls fetch while the whole line is filled over a req/ack, beat-per-cycle port.
module icache_dm #(
  parameter int INDEX_BITS = 6,
  parameter int WORD_BITS  = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr_address_fIF,
  output logic [31:0] Instr1_2IF,
  output logic        Stall_2IF,
  input  logic        Flush,
  output logic        Mem_req,
  output logic [31:0] Mem_addr,
  input  logic        Mem_ack,
  input  logic        Mem_valid,
  input  logic [31:0] Mem_data,
  output logic [31:0] Hit_count,
  output logic [31:0] Miss_count
);
  localparam int OFF_BITS = WORD_BITS + 2;
  localparam int TAG_BITS = 32 - INDEX_BITS - OFF_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << (INDEX_BITS + WORD_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          miss_addr_q, miss_addr_d;
  logic [WORD_BITS-1:0] beat_cnt_q, beat_cnt_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [31:0]          hit_cnt_q, hit_cnt_d;
  logic [31:0]          miss_cnt_q, miss_cnt_d;
  logic                 mem_req_q, mem_req_d;
  logic                 flushed_q, flushed_d;

  logic [31:0]          data_q [WORDS];
  logic [TAG_BITS-1:0]  tag_q  [LINES];

  logic [TAG_BITS-1:0]   tag_s, miss_tag_s;
  logic [INDEX_BITS-1:0] index_s, miss_index_s;
  logic [WORD_BITS-1:0]  word_s;
  logic                  hit_s, fill_we_s, last_beat_s, unused_s;

  assign word_s       = Instr_address_fIF[OFF_BITS-1:2];
  assign index_s      = Instr_address_fIF[OFF_BITS +: INDEX_BITS];
  assign tag_s        = Instr_address_fIF[31 -: TAG_BITS];
  assign miss_index_s = miss_addr_q[OFF_BITS +: INDEX_BITS];
  assign miss_tag_s   = miss_addr_q[31 -: TAG_BITS];
  assign unused_s     = ^Instr_address_fIF[1:0];

  assign hit_s       = valid_q[index_s] && (tag_q[index_s] == tag_s);
  assign fill_we_s   = (state_q == FILL) && Mem_valid;
  assign last_beat_s = fill_we_s && (beat_cnt_q == {WORD_BITS{1'b1}});

  assign Instr1_2IF = (state_q == IDLE) ? data_q[{index_s, word_s}] : 32'd0;
  assign Stall_2IF  = !((state_q == IDLE) && hit_s);
  assign Mem_req    = mem_req_q;
  assign Mem_addr   = miss_addr_q;
  assign Hit_count  = hit_cnt_q;
  assign Miss_count = miss_cnt_q;

  // Next-state logic: lookup/miss detection, request handshake and line fill.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    beat_cnt_d  = beat_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    mem_req_d   = mem_req_q;
    valid_d     = Flush ? {LINES{1'b0}} : valid_q;
    // A flush seen while a fill is outstanding must keep that line invalid.
    flushed_d   = flushed_q | Flush;
    case (state_q)
      IDLE: begin
        if (hit_s) begin
          hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
          miss_addr_d = {tag_s, index_s, {OFF_BITS{1'b0}}};
          miss_cnt_d  = miss_cnt_q + 32'd1;
          mem_req_d   = 1'b1;
          flushed_d   = 1'b0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (Mem_ack) begin
          mem_req_d  = 1'b0;
          beat_cnt_d = {WORD_BITS{1'b0}};
          state_d    = FILL;
        end else begin
          mem_req_d  = 1'b1;
        end
      end
      FILL: begin
        if (fill_we_s) begin
          beat_cnt_d = beat_cnt_q + WORD_BITS'(1);
          if (last_beat_s) begin
            state_d = IDLE;
            if (!flushed_d) begin
              valid_d[miss_index_s] = 1'b1;
            end else begin
              valid_d = {LINES{1'b0}};
            end
          end else begin
            state_d = FILL;
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      miss_addr_q <= 32'd0;
      beat_cnt_q  <= {WORD_BITS{1'b0}};
      valid_q     <= {LINES{1'b0}};
      hit_cnt_q   <= 32'd0;
      miss_cnt_q  <= 32'd0;
      mem_req_q   <= 1'b0;
      flushed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      beat_cnt_q  <= beat_cnt_d;
      valid_q     <= valid_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      mem_req_q   <= mem_req_d;
      flushed_q   <= flushed_d;
    end
  end

  // Data and tag arrays: written only by fill beats, never reset.
  always_ff @(posedge CLK) begin
    if (RESET && fill_we_s) begin
      data_q[{miss_index_s, beat_cnt_q}] <= Mem_data;
      if (last_beat_s) begin
        tag_q[miss_index_s] <= miss_tag_s;
      end
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: vector table of fetches plus hand-written
// flush-during-fill and reset-during-fill sequences, with a data scoreboard.
module tb_icache_dm;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] Instr_address_fIF = 32'd0;
  logic [31:0] Instr1_2IF;
  logic        Stall_2IF;
  logic        Flush = 1'b0;
  logic        Mem_req;
  logic [31:0] Mem_addr;
  logic        Mem_ack;
  logic        Mem_valid;
  logic [31:0] Mem_data;
  logic [31:0] Hit_count;
  logic [31:0] Miss_count;

  icache_dm #(.INDEX_BITS(6), .WORD_BITS(2)) dut (
    .CLK(CLK), .RESET(RESET), .Instr_address_fIF(Instr_address_fIF),
    .Instr1_2IF(Instr1_2IF), .Stall_2IF(Stall_2IF), .Flush(Flush),
    .Mem_req(Mem_req), .Mem_addr(Mem_addr), .Mem_ack(Mem_ack),
    .Mem_valid(Mem_valid), .Mem_data(Mem_data),
    .Hit_count(Hit_count), .Miss_count(Miss_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int          ack;
    bit          gap;
    int          stall;
    int          miss_inc;
  } vec_t;

  vec_t        vecs [12];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_hit = 32'd0;
  logic [31:0] exp_miss = 32'd0;
  logic [31:0] exp_q [$];
  logic [31:0] req_addr_q [$];
  int          ack_delay = 0;
  bit          gapped = 1'b0;
  int          cur_beat = -1;
  int          addr_unstable = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    case (w)
      32'hBFC0_0000: return 32'h0000_0011;
      32'hBFC0_0004: return 32'h0000_0022;
      32'hBFC0_0008: return 32'h0000_0033;
      32'hBFC0_000C: return 32'h0000_0044;
      default:       return w ^ 32'h5EED_0F0F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: ack after ack_delay cycles, then four ascending beats.
  initial begin
    logic [31:0] base;
    Mem_ack = 1'b0;
    Mem_valid = 1'b0;
    Mem_data = 32'd0;
    forever begin
      @(negedge CLK);
      if (Mem_req === 1'b1) begin
        base = Mem_addr;
        req_addr_q.push_back(base);
        for (int i = 0; i < ack_delay; i++) begin
          @(negedge CLK);
          if (Mem_addr !== base) addr_unstable++;
        end
        Mem_ack = 1'b1;
        @(negedge CLK);
        Mem_ack = 1'b0;
        for (int b = 0; b < 4; b++) begin
          cur_beat = b;
          Mem_valid = 1'b1;
          Mem_data = mem_word(base + 32'(4 * b));
          @(negedge CLK);
          Mem_valid = 1'b0;
          Mem_data = 32'd0;
          cur_beat = -1;
          if (gapped && b < 3) @(negedge CLK);
        end
      end
    end
  end

  task automatic wait_and_check(input logic [31:0] a, input int exp_stall, input int exp_miss_inc);
    int          stalls;
    bit          done;
    logic [31:0] e;
    stalls = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (Stall_2IF === 1'b0) begin
        done = 1'b1;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("instr_data", Instr1_2IF, e);
        end else begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_empty: output 0x%08h with nothing expected", Instr1_2IF);
        end
      end else begin
        stalls++;
        @(negedge CLK);
        #1;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL fetch_timeout: addr 0x%08h still stalled, expected release", a);
      exp_q.delete();
    end
    check("stall_cycles", stalls, exp_stall);
    for (int k = 0; k < exp_miss_inc; k++) begin
      if (req_addr_q.size() > 0) begin
        check("mem_addr", req_addr_q.pop_front(), {a[31:4], 4'h0});
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL mem_req_missing: got no request, expected line 0x%08h", {a[31:4], 4'h0});
      end
    end
    @(posedge CLK);
    #1;
    exp_hit = exp_hit + 32'd1;
    exp_miss = exp_miss + 32'(exp_miss_inc);
    check("hit_count", Hit_count, exp_hit);
    check("miss_count", Miss_count, exp_miss);
  endtask

  task automatic fetch(input logic [31:0] a, input int exp_stall, input int exp_miss_inc);
    @(negedge CLK);
    RESET = 1'b1;
    Instr_address_fIF = a;
    exp_q.push_back(mem_word(a));
    #1;
    wait_and_check(a, exp_stall, exp_miss_inc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    vecs[0]  = '{32'hBFC0_0000, 0, 1'b0, 6,  1};
    vecs[1]  = '{32'hBFC0_0004, 0, 1'b0, 0,  0};
    vecs[2]  = '{32'hBFC0_0008, 0, 1'b0, 0,  0};
    vecs[3]  = '{32'hBFC0_000C, 0, 1'b0, 0,  0};
    vecs[4]  = '{32'hBFC0_0400, 0, 1'b0, 6,  1};
    vecs[5]  = '{32'hBFC0_0000, 0, 1'b0, 6,  1};
    vecs[6]  = '{32'h0000_2058, 3, 1'b1, 12, 1};
    vecs[7]  = '{32'h0000_2050, 0, 1'b0, 0,  0};
    vecs[8]  = '{32'h0000_2054, 0, 1'b0, 0,  0};
    vecs[9]  = '{32'h0000_205C, 0, 1'b0, 0,  0};
    vecs[10] = '{32'hBFC0_0008, 0, 1'b0, 0,  0};
    vecs[11] = '{32'hFFFF_FFFC, 0, 1'b0, 6,  1};

    repeat (3) @(negedge CLK);
    #1;
    check("reset_stall", {31'd0, Stall_2IF}, 32'd1);
    check("reset_mem_req", {31'd0, Mem_req}, 32'd0);
    check("reset_mem_addr", Mem_addr, 32'd0);
    check("reset_hit_count", Hit_count, 32'd0);
    check("reset_miss_count", Miss_count, 32'd0);

    for (int v = 0; v < 12; v++) begin
      ack_delay = vecs[v].ack;
      gapped = vecs[v].gap;
      fetch(vecs[v].addr, vecs[v].stall, vecs[v].miss_inc);
    end

    // Flush during beat 2: line stays invalid, so the held address refills.
    ack_delay = 0;
    gapped = 1'b0;
    fork
      fetch(32'h0000_3070, 12, 2);
      begin
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
          @(negedge CLK);
          #1;
          if (cur_beat == 2) begin
            Flush = 1'b1;
            @(negedge CLK);
            Flush = 1'b0;
            seen = 1'b1;
            @(negedge CLK);
            #1;
            check("post_flush_mem_req", {31'd0, Mem_req}, 32'd0);
            check("post_flush_stall", {31'd0, Stall_2IF}, 32'd1);
          end
        end
        check("flush_beat_seen", {31'd0, seen}, 32'd1);
      end
    join
    fetch(32'hBFC0_000C, 6, 1);

    // Reset while beat 2 is on the bus.
    @(negedge CLK);
    Instr_address_fIF = 32'h0000_40A4;
    exp_q.push_back(mem_word(32'h0000_40A4));
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge CLK);
      #1;
      if (cur_beat == 1) seen = 1'b1;
    end
    check("reset_fill_beat_seen", {31'd0, seen}, 32'd1);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("midfill_reset_mem_req", {31'd0, Mem_req}, 32'd0);
    check("midfill_reset_mem_addr", Mem_addr, 32'd0);
    check("midfill_reset_stall", {31'd0, Stall_2IF}, 32'd1);
    check("midfill_reset_hits", Hit_count, 32'd0);
    check("midfill_reset_misses", Miss_count, 32'd0);
    exp_hit = 32'd0;
    exp_miss = 32'd0;
    if (req_addr_q.size() > 0) begin
      check("abandoned_mem_addr", req_addr_q.pop_front(), 32'h0000_40A0);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL abandoned_req_missing: got no request, expected line 0x000040a0");
    end
    // One trailing abandoned beat delays the new ack by a cycle: 1+1+1+4 stalls.
    wait_and_check(32'h0000_40A4, 7, 1);
    fetch(32'h0000_40A0, 0, 0);
    fetch(32'h0000_40A8, 0, 0);
    fetch(32'h0000_40AC, 0, 0);

    check("mem_addr_stable", 32'(addr_unstable), 32'd0);
    check("no_extra_requests", 32'(req_addr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
